// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encoding, divide-by-zero constant and op decode helpers
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MUL   = 3'd4
    } muldiv_op_t;

    // Divide by zero skips the divider: hi takes the dividend, lo takes this value.
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    function automatic logic is_div(input muldiv_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input muldiv_op_t op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/muldiv_fixup.sv
// rtl/muldiv_fixup.sv - combinational sign handling around the unsigned mul/div units
module muldiv_fixup
    import muldiv_pkg::*;
(
    input  muldiv_op_t  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        sign_a,
    output logic        sign_b,
    output logic [31:0] abs_a,
    output logic [31:0] abs_b,
    input  muldiv_op_t  op,
    input  logic        neg_a,
    input  logic        neg_b,
    input  logic [63:0] mul_c,
    input  logic [63:0] div_c,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;

    // abs(0x8000_0000) wraps to itself, which the units read as +2^31
    always_comb begin
        sign_a = is_signed_op(req_op) & req_a[31];
        sign_b = is_signed_op(req_op) & req_b[31];
        abs_a  = sign_a ? (32'd0 - req_a) : req_a;
        abs_b  = sign_b ? (32'd0 - req_b) : req_b;
    end

    always_comb begin
        prod   = (neg_a ^ neg_b) ? (64'd0 - mul_c) : mul_c;
        quo    = (neg_a ^ neg_b) ? (32'd0 - div_c[31:0]) : div_c[31:0];
        rem    = neg_a ? (32'd0 - div_c[63:32]) : div_c[63:32];
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (is_div(op)) begin
            res_hi = rem;
            res_lo = quo;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - E-stage multiply/divide sequencer: launches a unit, stalls, writes hi/lo or gpr
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  muldiv_op_t  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic        stall,
    output logic        hi_we,
    output logic        lo_we,
    output logic        gpr_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata,
    output logic [31:0] gpr_wdata,
    output logic        mul_valid,
    output logic        div_valid,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    input  logic        mul_done,
    input  logic        div_done,
    input  logic [63:0] mul_c,
    input  logic [63:0] div_c
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    muldiv_op_t  op_r;
    logic        neg_a_r;
    logic        neg_b_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic        sign_a;
    logic        sign_b;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        sel_done;

    muldiv_fixup u_fixup (
        .req_op (req_op),
        .req_a  (req_a),
        .req_b  (req_b),
        .sign_a (sign_a),
        .sign_b (sign_b),
        .abs_a  (abs_a),
        .abs_b  (abs_b),
        .op     (op_r),
        .neg_a  (neg_a_r),
        .neg_b  (neg_b_r),
        .mul_c  (mul_c),
        .div_c  (div_c),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    assign sel_done = is_div(op_r) ? div_done : mul_done;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            op_r    <= OP_MULT;
            neg_a_r <= 1'b0;
            neg_b_r <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && !flush) begin
                        op_r    <= req_op;
                        neg_a_r <= sign_a;
                        neg_b_r <= sign_b;
                        a_r     <= abs_a;
                        b_r     <= abs_b;
                        if (is_div(req_op) && (req_b == 32'd0)) begin
                            hi_r  <= req_a;
                            lo_r  <= DIV0_LO;
                            state <= DONE;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (sel_done) begin
                        hi_r  <= res_hi;
                        lo_r  <= res_lo;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // resetn gates stall so the output is 0 even while the E stage holds req_valid
    assign stall     = resetn & (((state == IDLE) & req_valid & ~flush) | (state == BUSY));
    assign mul_valid = (state == BUSY) & ~flush & ~is_div(op_r);
    assign div_valid = (state == BUSY) & ~flush & is_div(op_r);
    assign op_a      = a_r;
    assign op_b      = b_r;

    assign hi_we     = (state == DONE) & ~flush & (op_r != OP_MUL);
    assign lo_we     = hi_we;
    assign gpr_we    = (state == DONE) & ~flush & (op_r == OP_MUL);
    assign hi_wdata  = hi_r;
    assign lo_wdata  = lo_r;
    assign gpr_wdata = lo_r;

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-002 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port req_valid, input, 1, E-stage multiply/divide request, held high while stalled.
REQ-004 SHALL have port req_op, input, 3, muldiv_op_t: MULT, MULTU, DIV, DIVU, MUL.
REQ-005 SHALL have ports req_a and req_b, input, 32 each, rs and rt operand values.
REQ-006 SHALL have port flush, input, 1, exception/flush cancelling the in-flight operation.
REQ-007 SHALL have port stall, output, 1, holds the E stage.
REQ-008 SHALL have ports hi_we, lo_we, gpr_we, output, 1 each, single-cycle write strobes.
REQ-009 SHALL have ports hi_wdata, lo_wdata, gpr_wdata, output, 32 each, result data.
REQ-010 SHALL have unit-side ports:
- mul_valid, div_valid, output, 1.
- op_a, op_b, output, 32.
- mul_done, div_done, input, 1.
- mul_c, div_c, input, 64; div_c = {remainder, quotient}.

Function
REQ-011 SHALL use FSM states IDLE, BUSY, DONE.
REQ-012 SHALL accept a request in IDLE when req_valid=1 and flush=0:
- register op, operand signs and absolute (signed ops) or raw (unsigned ops) operands;
- go to BUSY.
REQ-013 SHALL drive stall = (IDLE & req_valid & ~flush) | BUSY, combinationally; stall SHALL be 0 in DONE.
REQ-014 SHALL hold mul_valid (MULT/MULTU/MUL) or div_valid (DIV/DIVU) high for every BUSY cycle, with op_a/op_b stable from registers.
REQ-015 SHALL, in BUSY when the selected done=1, register the sign-fixed result and go to DONE.
REQ-016 SHALL, in DONE, pulse the write strobes for exactly one cycle, then return to IDLE; DONE SHALL NOT accept a new request.
REQ-017 SHALL apply these write rules:
- MULT/MULTU/DIV/DIVU: hi_we=lo_we=1, gpr_we=0.
- MUL: gpr_we=1, gpr_wdata = low 32 bits of the signed product, hi_we=lo_we=0.
REQ-018 SHALL apply these sign rules:
- MULT/MUL: 64-bit product negated (two's complement) when the operand signs differ.
- DIV: quotient negated when the signs differ; remainder negated when req_a is negative.
- abs(0x8000_0000) = 0x8000_0000, treated as unsigned.
- -2^31 / -1 yields quotient 0x8000_0000, remainder 0.
REQ-019 SHALL handle DIV/DIVU with req_b=0 without launching the divider: go directly IDLE->DONE with hi_wdata=req_a and lo_wdata=32'hFFFF_FFFF.
REQ-020 SHALL handle flush as follows:
- in BUSY: drop the unit valid the same cycle, return to IDLE, no write;
- in DONE: suppress all write strobes.
Units SHALL tolerate valid deasserting before done.
REQ-021 SHALL ignore done inputs outside BUSY and the done of the unselected unit.
REQ-022 SHALL never assert mul_valid and div_valid together.

Reset
REQ-023 SHALL, while resetn=0, force state=IDLE and clear all registers; all outputs SHALL be 0.
REQ-024 SHALL abort any in-flight operation on reset mid-operation, with no write after release.

Structure
REQ-025 SHALL define muldiv_op_t and the divide-by-zero constants in the shared header package; FSM state enum SHALL stay local.
REQ-026 SHALL place sign pre/post-processing in one sub-module, muldiv_fixup, which is purely combinational.

Verification
REQ-027 SHALL cover MULT 0xFFFF_FFFE x 3 -> stall for unit latency, then DONE with hi=0xFFFF_FFFF, lo=0xFFFF_FFFA, hi_we=lo_we=1 for one cycle.
REQ-028 SHALL cover DIV -7 / 2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF; DIVU 7 / 0 -> no div_valid, hi=7, lo=0xFFFF_FFFF.
REQ-029 SHALL cover MUL 0x8000_0000 x -1 -> gpr_wdata=0x8000_0000, gpr_we=1, hi_we=lo_we=0.
REQ-030 SHALL cover flush asserted on the second BUSY cycle of DIVU -> div_valid low the same cycle, state IDLE, no strobes.
REQ-031 SHALL cover back-to-back MULTU then DIVU with req_valid held -> exactly two write pulses, and the second request captured only after DONE.
REQ-032 SHALL cover resetn low mid-BUSY -> outputs 0 asynchronously; no write after release even if mul_done arrives.
